// File: rtl/alu_logic_unit_if.sv
// Bus interface for the ALU bitwise logic unit.
// Carries the operands, the select code and the registered result/flags.
// Optional macro LOGIC_UNIT_PARITY_EN adds the registered parity flag.
interface alu_logic_unit_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       sel;
    logic [WIDTH-1:0] c;
    logic             zero;
    logic             active;
`ifdef LOGIC_UNIT_PARITY_EN
    logic             parity;
`endif

    // Requester side: drives operands and select, observes the result.
    modport master (
        output a, b, sel,
        input  c, zero, active
`ifdef LOGIC_UNIT_PARITY_EN
        , input parity
`endif
    );

    // Logic unit side: consumes operands and select, drives the result.
    modport slave (
        input  a, b, sel,
        output c, zero, active
`ifdef LOGIC_UNIT_PARITY_EN
        , output parity
`endif
    );
endinterface

// File: rtl/alu_logic_unit.sv
// Registered bitwise logic unit for the ALU datapath.
// Select codes 8..15 pick one of eight bitwise operations; codes 0..7 belong
// to the arithmetic unit and leave the held result untouched. The result and
// its zero flag update together one cycle after the inputs are sampled.
// Optional macro LOGIC_UNIT_PARITY_EN adds a registered parity flag of c.
// WIDTH must match the WIDTH of the connected alu_logic_unit_if.
module alu_logic_unit #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    alu_logic_unit_if.slave   bus
);

    // Upper half of the ALU select space; the MSB set marks a logic op.
    typedef enum logic [3:0] {
        OP_AND  = 4'd8,
        OP_OR   = 4'd9,
        OP_XOR  = 4'd10,
        OP_NAND = 4'd11,
        OP_NOR  = 4'd12,
        OP_XNOR = 4'd13,
        OP_NOTA = 4'd14,
        OP_NOTB = 4'd15
    } logic_op_e;

    logic [WIDTH-1:0] c_q;
    logic             zero_q;
    logic             active_q;
    logic [WIDTH-1:0] op_result;
    logic [WIDTH-1:0] next_c;
    logic             is_logic;
    logic             next_zero;
    logic_op_e        op;

    assign op       = logic_op_e'(bus.sel);
    assign is_logic = bus.sel[3];

    // Decode the select code into the bitwise result for this cycle.
    always_comb begin
        // NOTE: default assigned before the case so no path leaves op_result
        // unassigned, which would otherwise infer a latch.
        op_result = '0;
        case (op)
            OP_AND:  op_result = bus.a & bus.b;
            OP_OR:   op_result = bus.a | bus.b;
            OP_XOR:  op_result = bus.a ^ bus.b;
            OP_NAND: op_result = ~(bus.a & bus.b);
            OP_NOR:  op_result = ~(bus.a | bus.b);
            OP_XNOR: op_result = ~(bus.a ^ bus.b);
            OP_NOTA: op_result = ~bus.a;
            OP_NOTB: op_result = ~bus.b;
            default: op_result = '0;
        endcase
    end

    // Select the next result: new value on logic codes, held value otherwise.
    // The flags derive from next_c so they always agree with the stored c.
    always_comb begin
        next_c    = is_logic ? op_result : c_q;
        next_zero = ~|next_c;
    end

    // Result and flag registers; synchronous reset wins over any operation.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, independent of statement order.
        if (rst) begin
            c_q      <= '0;
            zero_q   <= 1'b1;
            active_q <= 1'b0;
        end else begin
            c_q      <= next_c;
            zero_q   <= next_zero;
            active_q <= is_logic;
        end
    end

`ifdef LOGIC_UNIT_PARITY_EN
    logic parity_q;

    // Parity of the new result, held along with c on arithmetic codes.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^next_c;
        end
    end

    assign bus.parity = parity_q;
`endif

    assign bus.c      = c_q;
    assign bus.zero   = zero_q;
    assign bus.active = active_q;

endmodule

// File: tb/tb_alu_logic_unit.sv
// Self-checking bench for alu_logic_unit: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
// Optional macro LOGIC_UNIT_PARITY_EN also checks the parity output.
module tb_alu_logic_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int total  = 0;
    int passed = 0;

    // Behavioural model of the registered outputs.
    logic [7:0] m_c;
    logic       m_zero;
    logic       m_active;
    logic       m_par;

    alu_logic_unit_if #(.WIDTH(8)) bus ();

    alu_logic_unit #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Codes 11..13 are the complements of 8..10; 14/15 invert one operand.
    function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] y, input int code);
        int k;
        logic [7:0] r;
        k = code - 8;
        if (k == 6) return ~x;
        if (k == 7) return ~y;
        case (k % 3)
            0:       r = x & y;
            1:       r = x | y;
            default: r = x ^ y;
        endcase
        return (k >= 3) ? ~r : r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Apply one cycle of inputs, advance the model, and compare all outputs.
    task automatic step(input logic r, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [3:0] is, input string tag);
        rst     = r;
        bus.a   = ia;
        bus.b   = ib;
        bus.sel = is;
        @(posedge clk);
        #1;
        if (r) begin
            m_c      = 8'h00;
            m_active = 1'b0;
        end else if (is >= 4'd8) begin
            m_c      = ref_op(ia, ib, int'(is));
            m_active = 1'b1;
        end else begin
            m_active = 1'b0;
        end
        m_zero = (m_c == 8'h00);
        m_par  = ^m_c;
        chk({tag, "_c"},      32'(bus.c),      32'(m_c));
        chk({tag, "_zero"},   32'(bus.zero),   32'(m_zero));
        chk({tag, "_active"}, 32'(bus.active), 32'(m_active));
`ifdef LOGIC_UNIT_PARITY_EN
        chk({tag, "_parity"}, 32'(bus.parity), 32'(m_par));
`endif
    endtask

    logic [7:0] sweep_exp [8];

    initial begin
        sweep_exp = '{8'h02, 8'h03, 8'h01, 8'hFD, 8'hFC, 8'hFE, 8'hFD, 8'hFC};
        m_c = 8'h00; m_zero = 1'b1; m_active = 1'b0; m_par = 1'b0;

        // Reset held two cycles with a live logic op on the inputs.
        step(1'b1, 8'hFF, 8'h00, 4'd9, "reset0");
        step(1'b1, 8'hFF, 8'h00, 4'd9, "reset1");
        chk("reset_c_const", 32'(bus.c), 32'h00);
        chk("reset_zero_const", 32'(bus.zero), 32'd1);
        step(1'b0, 8'hFF, 8'h00, 4'd9, "post_reset");
        chk("post_reset_c_const", 32'(bus.c), 32'hFF);
        chk("post_reset_active_const", 32'(bus.active), 32'd1);

        // Sweep every logic code, each held five cycles.
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 5; j++) begin
                step(1'b0, 8'h02, 8'h03, 4'(8 + i), "sweep");
                chk("sweep_c_const", 32'(bus.c), 32'(sweep_exp[i]));
                chk("sweep_zero_const", 32'(bus.zero), 32'd0);
            end
        end

        // Zero flag set then cleared.
        step(1'b0, 8'hAA, 8'h55, 4'd8, "zero_and");
        chk("zero_and_flag_const", 32'(bus.zero), 32'd1);
        step(1'b0, 8'hAA, 8'h55, 4'd9, "zero_or");
        chk("zero_or_c_const", 32'(bus.c), 32'hFF);

        // Hold on arithmetic codes while operands change.
        step(1'b0, 8'h0F, 8'hF0, 4'd10, "hold_setup");
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'($urandom), 8'($urandom), 4'd3, "hold");
            chk("hold_c_const", 32'(bus.c), 32'hFF);
            chk("hold_active_const", 32'(bus.active), 32'd0);
        end

        // Back-to-back toggling with a one-cycle reset pulse mid-stream.
        for (int i = 0; i < 6; i++)
            step(1'b0, 8'hC3, 8'h3C, (i % 2 == 0) ? 4'd8 : 4'd9, "toggle");
        step(1'b1, 8'hC3, 8'h3C, 4'd9, "toggle_rst");
        chk("toggle_rst_c_const", 32'(bus.c), 32'h00);
        for (int i = 0; i < 4; i++)
            step(1'b0, 8'hC3, 8'h3C, (i % 2 == 0) ? 4'd9 : 4'd8, "toggle_resume");

`ifdef LOGIC_UNIT_PARITY_EN
        step(1'b0, 8'h07, 8'h00, 4'd9, "parity_or");
        chk("parity_or_const", 32'(bus.parity), 32'd1);
        step(1'b0, 8'h07, 8'h00, 4'd8, "parity_and");
        chk("parity_and_const", 32'(bus.parity), 32'd0);
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 31) == 0), 8'($urandom), 8'($urandom),
                 4'($urandom_range(0, 15)), "rand");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
